// File: rtl/e203_exu_alu_dpath_arb_pkg.sv
// Shared constants for the ALU datapath arbiter: requester indices, state encoding, lock timeout.
// Pure definitions, no logic.
// No flow control.
package e203_exu_alu_dpath_arb_pkg;

    localparam int ARB_ALU = 0;
    localparam int ARB_BJP = 1;
    localparam int ARB_AGU = 2;
    localparam int ARB_MDV = 3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOCK_AGU = 2'd1;
    localparam logic [1:0] ST_LOCK_MDV = 2'd2;

    localparam int MAX_LOCK_CYC_DFLT = 40;
    localparam int LCNT_W_DFLT       = 6;

endpackage

// File: rtl/e203_gnrl_rr_arb4.sv
// 4-way round-robin picker: first asserted req at or after ptr, wrapping.
// Combinational, zero latency.
// No backpressure; gnt is one-hot0.
module e203_gnrl_rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld
);

    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        gnt_idx = ptr;
        gnt_vld = 1'b0;
        idx     = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
        end
        gnt = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
    end

endmodule

// File: rtl/e203_exu_alu_dpath_arb.sv
// Arbitrates the shared ALU datapath among ALU/BJP/AGU/MULDIV with multi-cycle locks for AGU and MULDIV.
// Grants are combinational (zero latency); dpath_locked and lock_err are registered.
// Losers are simply not granted and must hold vld; a lock owner's vld=0 is a bubble that keeps the lock.
module e203_exu_alu_dpath_arb
    import e203_exu_alu_dpath_arb_pkg::*;
#(
    parameter int MAX_LOCK_CYC = MAX_LOCK_CYC_DFLT,
    parameter int LCNT_W       = LCNT_W_DFLT
) (
    input  logic clk,
    input  logic rst,
    input  logic alu_req_vld,
    input  logic bjp_req_vld,
    input  logic agu_req_vld,
    input  logic agu_req_lock,
    input  logic mdv_req_vld,
    input  logic mdv_req_lock,
    input  logic flush,
    output logic alu_req_alu,
    output logic bjp_req_alu,
    output logic agu_req_alu,
    output logic mdv_req_alu,
    output logic dpath_locked,
    output logic lock_err
);

    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(MAX_LOCK_CYC);

    logic [1:0]        state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              lock_err_q, lock_err_d;

    logic [3:0] req, rr_gnt, gnt;
    logic [1:0] rr_idx;
    logic       rr_vld;
    logic       owner_vld, owner_lock;
    int         owner_idx;

    assign req = {mdv_req_vld, agu_req_vld, bjp_req_vld, alu_req_vld};

    e203_gnrl_rr_arb4 u_rr (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    always_comb begin
        gnt        = 4'b0000;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        lock_err_d = lock_err_q;
        owner_idx  = (state_q == ST_LOCK_AGU) ? ARB_AGU : ARB_MDV;
        owner_vld  = (state_q == ST_LOCK_AGU) ? agu_req_vld  : mdv_req_vld;
        owner_lock = (state_q == ST_LOCK_AGU) ? agu_req_lock : mdv_req_lock;

        // Flush beats everything, including a pending forced release.
        if (flush) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gnt = rr_gnt;
                    if (rr_vld) begin
                        rr_ptr_d = rr_idx + 2'd1;
                        if (rr_gnt[ARB_AGU] && agu_req_lock) begin
                            state_d    = ST_LOCK_AGU;
                            lock_cnt_d = LCNT_W'(1);
                        end else if (rr_gnt[ARB_MDV] && mdv_req_lock) begin
                            state_d    = ST_LOCK_MDV;
                            lock_cnt_d = LCNT_W'(1);
                        end
                    end
                end
                ST_LOCK_AGU, ST_LOCK_MDV: begin
                    if (lock_cnt_q >= LCNT_MAX) begin
                        state_d    = ST_IDLE;
                        lock_cnt_d = '0;
                        lock_err_d = 1'b1;
                    end else begin
                        gnt[owner_idx] = owner_vld;
                        if (owner_vld && !owner_lock) begin
                            state_d    = ST_IDLE;
                            lock_cnt_d = '0;
                        end else begin
                            lock_cnt_d = lock_cnt_q + LCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 2'd0;
            lock_cnt_q <= '0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign alu_req_alu  = gnt[ARB_ALU] & ~rst;
    assign bjp_req_alu  = gnt[ARB_BJP] & ~rst;
    assign agu_req_alu  = gnt[ARB_AGU] & ~rst;
    assign mdv_req_alu  = gnt[ARB_MDV] & ~rst;
    assign dpath_locked = (state_q != ST_IDLE);
    assign lock_err     = lock_err_q;

endmodule

// File: tb/tb_e203_exu_alu_dpath_arb.sv
// Directed bench for the ALU datapath arbiter.
module tb_e203_exu_alu_dpath_arb;

    logic clk = 1'b0;
    logic rst;
    logic alu_req_vld, bjp_req_vld, agu_req_vld, agu_req_lock;
    logic mdv_req_vld, mdv_req_lock, flush;
    logic alu_req_alu, bjp_req_alu, agu_req_alu, mdv_req_alu;
    logic dpath_locked, lock_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e203_exu_alu_dpath_arb dut (
        .clk          (clk),
        .rst          (rst),
        .alu_req_vld  (alu_req_vld),
        .bjp_req_vld  (bjp_req_vld),
        .agu_req_vld  (agu_req_vld),
        .agu_req_lock (agu_req_lock),
        .mdv_req_vld  (mdv_req_vld),
        .mdv_req_lock (mdv_req_lock),
        .flush        (flush),
        .alu_req_alu  (alu_req_alu),
        .bjp_req_alu  (bjp_req_alu),
        .agu_req_alu  (agu_req_alu),
        .mdv_req_alu  (mdv_req_alu),
        .dpath_locked (dpath_locked),
        .lock_err     (lock_err)
    );

    logic [3:0] gnt;
    assign gnt = {mdv_req_alu, agu_req_alu, bjp_req_alu, alu_req_alu};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic a, input logic b, input logic g, input logic gl,
                           input logic m, input logic ml);
        alu_req_vld  = a;
        bjp_req_vld  = b;
        agu_req_vld  = g;
        agu_req_lock = gl;
        mdv_req_vld  = m;
        mdv_req_lock = ml;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        set_req(1, 1, 1, 0, 1, 0);

        // Reset: everything requesting, nothing granted.
        mid;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_locked", 32'(dpath_locked), 32'h0);
        chk("rst_err", 32'(lock_err), 32'h0);
        next_cyc;
        next_cyc;
        rst = 1'b0;

        // Round robin from ALU, full rotation twice.
        for (int i = 0; i < 8; i++) begin
            mid;
            chk($sformatf("rr_%0d", i), 32'(gnt), 32'(4'b0001 << (i % 4)));
            next_cyc;
        end

        // Single AGU grant moves rr_ptr to MDV.
        set_req(0, 0, 1, 0, 0, 0);
        mid;
        chk("agu_single", 32'(gnt), 32'h4);
        next_cyc;

        // MDV lock 34 cycles with ALU competing.
        set_req(1, 0, 0, 0, 1, 1);
        for (int n = 1; n <= 34; n++) begin
            mid;
            chk($sformatf("mdv_lock_gnt_%0d", n), 32'(gnt), 32'h8);
            chk($sformatf("mdv_lock_lk_%0d", n), 32'(dpath_locked), (n == 1) ? 32'h0 : 32'h1);
            next_cyc;
        end
        set_req(1, 0, 0, 0, 1, 0);
        mid;
        chk("mdv_final_gnt", 32'(gnt), 32'h8);
        chk("mdv_final_lk", 32'(dpath_locked), 32'h1);
        next_cyc;
        set_req(1, 0, 0, 0, 0, 0);
        mid;
        chk("mdv_after_lk", 32'(dpath_locked), 32'h0);
        chk("mdv_after_alu", 32'(gnt), 32'h1);
        next_cyc;

        // AGU lock held until forced release at lock_cnt==40.
        set_req(0, 0, 1, 1, 0, 0);
        for (int c = 1; c <= 50; c++) begin
            mid;
            if (c == 41) begin
                chk("to_nogrant", 32'(gnt), 32'h0);
                chk("to_lk", 32'(dpath_locked), 32'h1);
                chk("to_cnt", 32'(dut.lock_cnt_q), 32'd40);
                chk("to_err_pre", 32'(lock_err), 32'h0);
            end else begin
                chk($sformatf("to_gnt_%0d", c), 32'(gnt), 32'h4);
            end
            if (c == 42) begin
                chk("to_idle", 32'(dpath_locked), 32'h0);
                chk("to_err", 32'(lock_err), 32'h1);
            end
            next_cyc;
        end

        // Owner bubble on the re-taken AGU lock (entered at c=42, cnt now 9).
        set_req(0, 1, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            mid;
            chk($sformatf("bub_gnt_%0d", b), 32'(gnt), 32'h0);
            chk($sformatf("bub_lk_%0d", b), 32'(dpath_locked), 32'h1);
            chk($sformatf("bub_cnt_%0d", b), 32'(dut.lock_cnt_q), 32'(9 + b));
            next_cyc;
        end
        mid;
        chk("bub_cnt_end", 32'(dut.lock_cnt_q), 32'd12);
        chk("err_sticky", 32'(lock_err), 32'h1);

        // Reset clears the sticky error and the lock.
        rst = 1'b1;
        mid;
        chk("rst2_gnt", 32'(gnt), 32'h0);
        next_cyc;
        rst = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        mid;
        chk("rst2_err", 32'(lock_err), 32'h0);
        chk("rst2_lk", 32'(dpath_locked), 32'h0);

        // MDV locked 10 cycles, then flush with BJP requesting.
        set_req(0, 0, 0, 0, 1, 1);
        for (int c = 1; c <= 10; c++) begin
            mid;
            chk($sformatf("fl_gnt_%0d", c), 32'(gnt), 32'h8);
            next_cyc;
        end
        flush = 1'b1;
        set_req(0, 1, 0, 0, 1, 1);
        mid;
        chk("fl_nogrant", 32'(gnt), 32'h0);
        chk("fl_lk", 32'(dpath_locked), 32'h1);
        next_cyc;
        flush = 1'b0;
        set_req(0, 1, 0, 0, 0, 0);
        mid;
        chk("fl_idle", 32'(dpath_locked), 32'h0);
        chk("fl_bjp", 32'(gnt), 32'h2);
        chk("fl_err", 32'(lock_err), 32'h0);
        next_cyc;

        // Flush in IDLE suppresses grants.
        flush = 1'b1;
        set_req(1, 1, 0, 0, 0, 0);
        mid;
        chk("fl_idle_nogrant", 32'(gnt), 32'h0);
        next_cyc;
        flush = 1'b0;
        mid;
        chk("post_flush_alu", 32'(gnt), 32'h1);
        next_cyc;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
